// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared assembler state and flit record types for the NoC deserializer
package noc_pkg;

  // Upper bounds for the flit record fields; instances use the low FLIT_WIDTH / DEST_WIDTH bits.
  localparam int unsigned NOC_MAX_FLIT_WIDTH = 64;
  localparam int unsigned NOC_MAX_DEST_WIDTH = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } deser_state_e;

  typedef struct packed {
    logic [NOC_MAX_FLIT_WIDTH-1:0] data;
    logic [NOC_MAX_DEST_WIDTH-1:0] dest;
    logic                          is_tail;
  } flit_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// rtl/noc_flit_fifo.sv - synchronous FIFO holding incoming flits, first-word-fall-through read
module noc_flit_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array: data only, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/noc_flit_deserializer.sv
// rtl/noc_flit_deserializer.sv - credit-link flits to AXIS beats; error detection under NOC_DESER_ERR_CHECK_EN
module noc_flit_deserializer
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH           = 32,
  parameter int unsigned DEST_WIDTH           = 6,
  parameter int unsigned SERIALIZATION_FACTOR = 1,
  parameter int unsigned FLIT_BUFFER_DEPTH    = 2
) (
  input  logic                                     clk_noc,
  input  logic                                     rst_noc,
  input  logic [FLIT_WIDTH-1:0]                    data_in,
  input  logic [DEST_WIDTH-1:0]                    dest_in,
  input  logic                                     is_tail_in,
  input  logic                                     send_in,
  output logic                                     credit_out,
  output logic                                     axis_tvalid,
  input  logic                                     axis_tready,
  output logic [FLIT_WIDTH*SERIALIZATION_FACTOR-1:0] axis_tdata,
  output logic                                     axis_tlast,
  output logic [DEST_WIDTH-1:0]                    axis_tdest,
  output logic                                     err_overflow,
  output logic                                     err_framing
);

  localparam int unsigned K_W    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam int unsigned CNT_W  = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int unsigned BEAT_W = FLIT_WIDTH * SERIALIZATION_FACTOR;

  flit_t            in_flit, head_flit;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic             last_flit;

  deser_state_e      state_q;
  logic [K_W-1:0]    k_q;
  logic              tvalid_q, tlast_q, credit_q;
  logic [BEAT_W-1:0] tdata_q;
  logic [DEST_WIDTH-1:0] tdest_q;

  // Widen the incoming flit into the shared record; upper bits stay zero.
  always_comb begin
    in_flit                         = '0;
    in_flit.data[FLIT_WIDTH-1:0]    = data_in;
    in_flit.dest[DEST_WIDTH-1:0]    = dest_in;
    in_flit.is_tail                 = is_tail_in;
  end

  // Pops happen while collecting, or on the edge a held beat is accepted.
  assign fifo_pop  = !fifo_empty && ((state_q == COLLECT) || axis_tready);
  assign fifo_push = send_in && (!fifo_full || fifo_pop);
  assign last_flit = (k_q == K_W'(SERIALIZATION_FACTOR - 1));

  noc_flit_fifo #(
    .WIDTH ($bits(flit_t)),
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk_i   (clk_noc),
    .rst_i   (rst_noc),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_flit),
    .rdata_o (head_flit),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Assembler: packs SERIALIZATION_FACTOR flits LSB-first, then holds the beat until accepted
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state_q  <= COLLECT;
      k_q      <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tdest_q  <= '0;
    end else begin
      if (state_q == HOLD && axis_tready) begin
        state_q  <= COLLECT;
        tvalid_q <= 1'b0;
      end
      if (fifo_pop) begin
        for (int s = 0; s < SERIALIZATION_FACTOR; s++) begin
          if (k_q == K_W'(s)) begin
            tdata_q[s*FLIT_WIDTH +: FLIT_WIDTH] <= head_flit.data[FLIT_WIDTH-1:0];
          end
        end
        if (k_q == '0) begin
          tdest_q <= head_flit.dest[DEST_WIDTH-1:0];
        end
        if (last_flit) begin
          tlast_q  <= head_flit.is_tail;
          tvalid_q <= 1'b1;
          state_q  <= HOLD;
          k_q      <= '0;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  // One credit pulse per popped flit, one cycle after the pop
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) credit_q <= 1'b0;
    else         credit_q <= fifo_pop;
  end

  assign credit_out  = credit_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tdata  = tdata_q;
  assign axis_tlast  = tlast_q;
  assign axis_tdest  = tdest_q;

`ifdef NOC_DESER_ERR_CHECK_EN
  logic overflow_q, framing_q;

  // Sticky error flags; only reset clears them
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      overflow_q <= 1'b0;
      framing_q  <= 1'b0;
    end else begin
      if (send_in && fifo_full && !fifo_pop)               overflow_q <= 1'b1;
      if (fifo_pop && !last_flit && head_flit.is_tail)     framing_q  <= 1'b1;
    end
  end

  assign err_overflow = overflow_q;
  assign err_framing  = framing_q;
`else
  assign err_overflow = 1'b0;
  assign err_framing  = 1'b0;
`endif

  // Record bits above the configured widths and the occupancy count are intentionally unread.
  logic unused_bits;
  assign unused_bits = ^{head_flit, fifo_count};

endmodule

// File: tb/tb_noc_flit_deserializer.sv
// tb/tb_noc_flit_deserializer.sv - self-checking bench for noc_flit_deserializer
module tb_noc_flit_deserializer;

`ifdef NOC_DESER_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SF=1, 32-bit flits
  logic [31:0] s1_data, s1_tdata;
  logic [5:0]  s1_dest, s1_tdest;
  logic s1_tail, s1_send, s1_credit, s1_tvalid, s1_tready, s1_tlast, s1_ovf, s1_frm;
  // SF=4, 8-bit flits
  logic [7:0]  s4_data;
  logic [31:0] s4_tdata;
  logic [5:0]  s4_dest, s4_tdest;
  logic s4_tail, s4_send, s4_credit, s4_tvalid, s4_tready, s4_tlast, s4_ovf, s4_frm;
  // SF=2, 8-bit flits
  logic [7:0]  s2_data;
  logic [15:0] s2_tdata;
  logic [5:0]  s2_dest, s2_tdest;
  logic s2_tail, s2_send, s2_credit, s2_tvalid, s2_tready, s2_tlast, s2_ovf, s2_frm;

  noc_flit_deserializer #(.FLIT_WIDTH(32), .DEST_WIDTH(6), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)) u_sf1 (
    .clk_noc(clk), .rst_noc(rst), .data_in(s1_data), .dest_in(s1_dest), .is_tail_in(s1_tail),
    .send_in(s1_send), .credit_out(s1_credit), .axis_tvalid(s1_tvalid), .axis_tready(s1_tready),
    .axis_tdata(s1_tdata), .axis_tlast(s1_tlast), .axis_tdest(s1_tdest),
    .err_overflow(s1_ovf), .err_framing(s1_frm));

  noc_flit_deserializer #(.FLIT_WIDTH(8), .DEST_WIDTH(6), .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(2)) u_sf4 (
    .clk_noc(clk), .rst_noc(rst), .data_in(s4_data), .dest_in(s4_dest), .is_tail_in(s4_tail),
    .send_in(s4_send), .credit_out(s4_credit), .axis_tvalid(s4_tvalid), .axis_tready(s4_tready),
    .axis_tdata(s4_tdata), .axis_tlast(s4_tlast), .axis_tdest(s4_tdest),
    .err_overflow(s4_ovf), .err_framing(s4_frm));

  noc_flit_deserializer #(.FLIT_WIDTH(8), .DEST_WIDTH(6), .SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(2)) u_sf2 (
    .clk_noc(clk), .rst_noc(rst), .data_in(s2_data), .dest_in(s2_dest), .is_tail_in(s2_tail),
    .send_in(s2_send), .credit_out(s2_credit), .axis_tvalid(s2_tvalid), .axis_tready(s2_tready),
    .axis_tdata(s2_tdata), .axis_tlast(s2_tlast), .axis_tdest(s2_tdest),
    .err_overflow(s2_ovf), .err_framing(s2_frm));

  int tests = 0;
  int fails = 0;
  int c1 = 0, c2 = 0, c4 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and tally credit pulses seen there.
  task automatic step();
    @(negedge clk);
    if (s1_credit) c1++;
    if (s2_credit) c2++;
    if (s4_credit) c4++;
  endtask

  task automatic wait_valid4(input string name);
    int n = 0;
    while (!s4_tvalid && n < 20) begin step(); n++; end
    chk(name, s4_tvalid, 1'b1);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [5:0]  dest;
    logic        tail;
    logic [31:0] exp_tdata;
    logic [5:0]  exp_tdest;
    logic        exp_tlast;
  } vec_t;

  // One flit through the SF=1 instance: idle, then valid exactly two cycles after it is driven.
  task automatic run_vec1(input vec_t v, input int idx);
    c1 = 0;
    s1_data = v.data; s1_dest = v.dest; s1_tail = v.tail; s1_send = 1'b1;
    step();
    chk($sformatf("v%0d_not_yet_valid", idx), s1_tvalid, 1'b0);
    s1_send = 1'b0;
    step();
    chk($sformatf("v%0d_valid", idx), s1_tvalid, 1'b1);
    chk($sformatf("v%0d_tdata", idx), s1_tdata, v.exp_tdata);
    chk($sformatf("v%0d_tdest", idx), s1_tdest, v.exp_tdest);
    chk($sformatf("v%0d_tlast", idx), s1_tlast, v.exp_tlast);
    chk($sformatf("v%0d_credit", idx), c1, 1);
    s1_tready = 1'b1;
    step();
    chk($sformatf("v%0d_done", idx), s1_tvalid, 1'b0);
    s1_tready = 1'b0;
    step();
    chk($sformatf("v%0d_one_credit", idx), c1, 1);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [5:0]  dest;
    logic        last;
  } beat_t;

  vec_t vecs[4];

  initial begin
    beat_t expq[$];
    beat_t e;
    logic [31:0] h_data;
    logic [5:0]  h_dest;
    logic        h_last;

    vecs[0] = '{32'hDEADBEEF, 6'h2A, 1'b1, 32'hDEADBEEF, 6'h2A, 1'b1};
    vecs[1] = '{32'h00000000, 6'h00, 1'b0, 32'h00000000, 6'h00, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 6'h3F, 1'b1, 32'hFFFFFFFF, 6'h3F, 1'b1};
    vecs[3] = '{32'h12345678, 6'h15, 1'b0, 32'h12345678, 6'h15, 1'b0};

    rst = 1'b1;
    {s1_data, s1_dest, s1_tail, s1_send, s1_tready} = '0;
    {s4_data, s4_dest, s4_tail, s4_send, s4_tready} = '0;
    {s2_data, s2_dest, s2_tail, s2_send, s2_tready} = '0;
    #2;
    chk("rst_sf1_outputs", {s1_tvalid, s1_credit, s1_tdata, s1_tlast, s1_tdest, s1_ovf, s1_frm}, '0);
    chk("rst_sf4_outputs", {s4_tvalid, s4_credit, s4_tdata, s4_tlast, s4_tdest, s4_ovf, s4_frm}, '0);
    chk("rst_sf2_outputs", {s2_tvalid, s2_credit, s2_tdata, s2_tlast, s2_tdest, s2_ovf, s2_frm}, '0);
    step(); step();
    rst = 1'b0;
    step();

    // Table of single-flit latency vectors
    for (int i = 0; i < 4; i++) run_vec1(vecs[i], i);

    // Backpressure: two flits, output held for 10 cycles with a single credit returned
    c1 = 0;
    s1_tready = 1'b0;
    s1_data = 32'hAAAA0001; s1_dest = 6'h01; s1_tail = 1'b0; s1_send = 1'b1;
    step();
    s1_data = 32'hBBBB0002; s1_dest = 6'h02; s1_tail = 1'b1;
    step();
    s1_send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", s1_tvalid, 1'b1);
      chk("bp_hold_data", s1_tdata, 32'hAAAA0001);
    end
    chk("bp_single_credit", c1, 1);
    s1_tready = 1'b1;
    step();
    chk("bp_second_valid", s1_tvalid, 1'b1);
    chk("bp_second_data", s1_tdata, 32'hBBBB0002);
    chk("bp_second_last", s1_tlast, 1'b1);
    chk("bp_second_credit", c1, 2);
    step();
    chk("bp_drained", s1_tvalid, 1'b0);
    s1_tready = 1'b0;

    // Overflow: one beat held, FIFO filled, fourth flit must be dropped
    c1 = 0;
    for (int i = 0; i < 4; i++) begin
      s1_data = 32'hC0DE0000 + i; s1_dest = 6'(i); s1_tail = 1'b0; s1_send = 1'b1;
      step();
    end
    s1_send = 1'b0;
    chk("ovf_flag", s1_ovf, ERR_EN);
    chk("ovf_held_data", s1_tdata, 32'hC0DE0000);
    chk("ovf_credit_so_far", c1, 1);
    s1_tready = 1'b1;
    step();
    chk("ovf_beat1", s1_tdata, 32'hC0DE0001);
    step();
    chk("ovf_beat2", s1_tdata, 32'hC0DE0002);
    chk("ovf_beat2_valid", s1_tvalid, 1'b1);
    step();
    chk("ovf_dropped_flit_absent", s1_tvalid, 1'b0);
    step();
    chk("ovf_total_credits", c1, 3);
    chk("ovf_flag_sticky", s1_ovf, ERR_EN);
    s1_tready = 1'b0;

    // Framing: tail on flit 0 of a two-flit beat
    c2 = 0;
    s2_data = 8'hAA; s2_dest = 6'h03; s2_tail = 1'b1; s2_send = 1'b1;
    step();
    s2_data = 8'hBB; s2_dest = 6'h09; s2_tail = 1'b0;
    step();
    s2_send = 1'b0;
    begin
      int n = 0;
      while (!s2_tvalid && n < 20) begin step(); n++; end
    end
    chk("frm_valid", s2_tvalid, 1'b1);
    chk("frm_tdata", s2_tdata, 16'hBBAA);
    chk("frm_tdest", s2_tdest, 6'h03);
    chk("frm_tlast", s2_tlast, 1'b0);
    chk("frm_flag", s2_frm, ERR_EN);
    chk("frm_credits", c2, 2);
    s2_tready = 1'b1;
    step();
    chk("frm_done", s2_tvalid, 1'b0);
    s2_tready = 1'b0;

    // Assembly of four 8-bit flits into one beat
    c4 = 0;
    for (int i = 0; i < 4; i++) begin
      s4_data = 8'(8'h11 * (i + 1)); s4_dest = (i == 0) ? 6'h15 : 6'h2E;
      s4_tail = (i == 3); s4_send = 1'b1;
      step();
    end
    s4_send = 1'b0;
    wait_valid4("asm_valid");
    chk("asm_tdata", s4_tdata, 32'h44332211);
    chk("asm_tdest", s4_tdest, 6'h15);
    chk("asm_tlast", s4_tlast, 1'b1);
    chk("asm_credits", c4, 4);
    chk("asm_no_framing", s4_frm, 1'b0);
    s4_tready = 1'b1;
    step();
    chk("asm_done", s4_tvalid, 1'b0);
    s4_tready = 1'b0;

    // Reset after the first of four flits
    c4 = 0;
    s4_data = 8'h55; s4_dest = 6'h07; s4_tail = 1'b0; s4_send = 1'b1;
    step();
    s4_send = 1'b0;
    step();
    chk("rmb_popped_credit", c4, 1);
    rst = 1'b1;
    #1;
    chk("rmb_outputs_zero", {s4_tvalid, s4_credit, s4_tdata, s4_tlast, s4_tdest, s4_ovf, s4_frm}, '0);
    chk("rmb_flags_cleared", {s1_ovf, s2_frm}, '0);
    c4 = 0;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("rmb_no_credit", c4, 0);
    chk("rmb_idle", s4_tvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s4_data = 8'(8'hA1 + 8'h11 * i); s4_dest = 6'(6'h20 + i); s4_tail = (i == 3); s4_send = 1'b1;
      step();
    end
    s4_send = 1'b0;
    wait_valid4("rmb_valid");
    chk("rmb_tdata", s4_tdata, 32'hD4C3B2A1);
    chk("rmb_tdest", s4_tdest, 6'h20);
    chk("rmb_tlast", s4_tlast, 1'b1);
    chk("rmb_credits", c4, 4);
    s4_tready = 1'b1;
    step();
    s4_tready = 1'b0;

    // Randomized credit-respecting traffic against a beat-level model
    begin
      localparam int NB = 60;
      int credits = 2;
      int sent = 0;
      int got = 0;
      int pend_cnt = 0;
      logic [31:0] pend_data = '0;
      logic [5:0]  pend_dest = '0;
      bit stalled = 0;
      bit r;
      logic [7:0] d;
      logic [5:0] dst;
      logic tl;
      for (int cyc = 0; cyc < 8000 && got < NB; cyc++) begin
        step();
        if (s4_credit) credits++;
        if (stalled) begin
          chk("rand_stall_valid", s4_tvalid, 1'b1);
          chk("rand_stall_data", {s4_tdata, s4_tdest, s4_tlast}, {h_data, h_dest, h_last});
        end
        r = ($urandom_range(0, 3) != 0);
        s4_tready = r;
        stalled = s4_tvalid && !r;
        h_data = s4_tdata; h_dest = s4_tdest; h_last = s4_tlast;
        if (s4_tvalid && r) begin
          if (expq.size() == 0) begin
            chk("rand_unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = expq.pop_front();
            chk("rand_tdata", s4_tdata, e.data);
            chk("rand_tdest", s4_tdest, e.dest);
            chk("rand_tlast", s4_tlast, e.last);
            got++;
          end
        end
        if (credits > 0 && sent < NB * 4 && $urandom_range(0, 2) != 0) begin
          d   = 8'($urandom);
          dst = 6'($urandom);
          tl  = (pend_cnt == 3) ? 1'($urandom) : 1'b0;
          s4_data = d; s4_dest = dst; s4_tail = tl; s4_send = 1'b1;
          credits--;
          sent++;
          pend_data = pend_data | (32'(d) << (8 * pend_cnt));
          if (pend_cnt == 0) pend_dest = dst;
          if (pend_cnt == 3) begin
            expq.push_back('{pend_data, pend_dest, tl});
            pend_data = '0;
            pend_cnt  = 0;
          end else begin
            pend_cnt++;
          end
        end else begin
          s4_send = 1'b0;
        end
      end
      s4_send = 1'b0;
      s4_tready = 1'b0;
      chk("rand_beats_received", got, NB);
      for (int i = 0; i < 6; i++) begin
        step();
        if (s4_credit) credits++;
      end
      chk("rand_credits_returned", credits, 2);
      chk("rand_no_errors", {s4_ovf, s4_frm}, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
